// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Per-stage control record: stage occupancy plus the registered group carry.
  typedef struct packed {
    logic valid;
    logic carry;
  } cla_stage_t;

  // Number of lookahead groups (and pipeline stages) needed to cover width bits.
  function automatic int unsigned cla_nstage(input int unsigned width, input int unsigned group);
    return (width + group - 1) / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational W-bit carry-lookahead group: prefix generate/propagate feed every carry directly from cin.
module cla_group #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         grp_g,
  output logic         grp_p
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] gpre;
  logic [W-1:0] ppre;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Prefix G/P over bits [i:0], then each carry is a single G | P&cin term.
  always_comb begin
    gpre    = '0;
    ppre    = '0;
    c       = '0;
    gpre[0] = g[0];
    ppre[0] = p[0];
    for (int i = 1; i < int'(W); i++) begin
      gpre[i] = g[i] | (p[i] & gpre[i-1]);
      ppre[i] = p[i] & ppre[i-1];
    end
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = gpre[i] | (ppre[i] & cin);
    end
  end

  assign sum   = p ^ c[W-1:0];
  assign cout  = c[W];
  assign grp_g = gpre[W-1];
  assign grp_p = ppre[W-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Requires WIDTH >= 2 and 1 <= GROUP <= WIDTH; the top group may be partial.
// Optional feature: define CLA_PIPE_OVFL_EN to add the registered signed-overflow output o_ovfl.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
`ifdef CLA_PIPE_OVFL_EN
  ,
  output logic             o_ovfl
`endif
);

  localparam int unsigned NSTAGE = cla_nstage(WIDTH, GROUP);

  logic en;

  // Whole pipeline advances together unless a held result is blocking the output.
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
    localparam int unsigned LO   = k * GROUP;
    localparam int unsigned RW   = WIDTH - LO;
    localparam int unsigned GW   = (RW < GROUP) ? RW : GROUP;
    localparam bit          LAST = (k == int'(NSTAGE) - 1);

    logic [RW-1:0]    a_in;
    logic [RW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [GW-1:0]    s_grp;
    logic             c_out;
    logic             gp_unused_g;
    logic             gp_unused_p;
    logic [LO+GW-1:0] s_next;
    logic [LO+GW-1:0] s_q;
    cla_stage_t       ctl_q;

    if (k == 0) begin : g_src
      // Entry stage: subtraction is folded in as A + ~B + 1.
      assign a_in   = i_add1;
      assign b_in   = i_sub ? ~i_add2 : i_add2;
      assign c_in   = i_sub | i_cin;
      assign v_in   = i_valid;
      assign s_next = s_grp;
    end else begin : g_src
      // Later stages consume the unresolved operand bits and carry left by the previous stage.
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].ctl_q.carry;
      assign v_in   = g_stage[k-1].ctl_q.valid;
      assign s_next = {s_grp, g_stage[k-1].s_q};
    end

    cla_group #(
      .W (GW)
    ) u_grp (
      .a     (a_in[GW-1:0]),
      .b     (b_in[GW-1:0]),
      .cin   (c_in),
      .sum   (s_grp),
      .cout  (c_out),
      .grp_g (gp_unused_g),
      .grp_p (gp_unused_p)
    );

    // Stage register: valid, group carry-out and the result bits resolved so far.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ctl_q <= '0;
        s_q   <= '0;
      end else if (en) begin
        ctl_q <= cla_stage_t'{valid: v_in, carry: c_out};
        s_q   <= s_next;
      end
    end

    if (!LAST) begin : g_fwd
      logic [RW-GW-1:0] a_q;
      logic [RW-GW-1:0] b_q;

      // Operand bits above this group travel on to the next stage.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[RW-1:GW];
          b_q <= b_in[RW-1:GW];
        end
      end
    end

`ifdef CLA_PIPE_OVFL_EN
    if (LAST) begin : g_ovfl
      logic ovfl_q;

      // Signed overflow: carry into the MSB (recovered from its sum bit) differs from carry out.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovfl_q <= 1'b0;
        end else if (en) begin
          ovfl_q <= (a_in[GW-1] ^ b_in[GW-1] ^ s_grp[GW-1]) ^ c_out;
        end
      end
    end
`endif
  end

  assign o_valid  = g_stage[NSTAGE-1].ctl_q.valid;
  assign o_result = {g_stage[NSTAGE-1].ctl_q.carry, g_stage[NSTAGE-1].s_q};

`ifdef CLA_PIPE_OVFL_EN
  assign o_ovfl = g_stage[NSTAGE-1].g_ovfl.ovfl_q;
`endif

endmodule
